// File: rtl/ram_fifo_stream_reader.sv
// Drains a show-ahead RAM FIFO into a valid/ready stream through a two-entry
// registered buffer (head + skid), tagging every PKT_LEN-th word as last.
module ram_fifo_stream_reader #(
    parameter int DATA_W  = 8,
    parameter int PKT_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_flush,
    output logic              o_fifo_rden,
    input  logic [DATA_W-1:0] i_fifo_rddata,
    input  logic              i_fifo_empty,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_pkt_done
);

    localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_t;

    occ_t              occ, occ_nxt;
    logic [DATA_W-1:0] head_data, head_data_nxt;
    logic [DATA_W-1:0] skid_data, skid_data_nxt;
    logic              head_last, head_last_nxt;
    logic              skid_last, skid_last_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              pkt_done, pkt_done_nxt;
    logic              push, pop, new_last;

    // Reads never look at i_ready; the skid entry absorbs the one word in flight.
    assign o_fifo_rden = i_en & ~i_fifo_empty & ~i_flush & ~rst & (occ != OCC_TWO);
    assign push        = o_fifo_rden;
    assign pop         = o_valid & i_ready;
    assign new_last    = (cnt == LAST_IDX);

    assign o_valid    = (occ != OCC_EMPTY);
    assign o_data     = head_data;
    assign o_last     = head_last;
    assign o_pkt_done = pkt_done;

    always_comb begin
        occ_nxt       = occ;
        head_data_nxt = head_data;
        head_last_nxt = head_last;
        skid_data_nxt = skid_data;
        skid_last_nxt = skid_last;
        cnt_nxt       = cnt;
        pkt_done_nxt  = 1'b0;

        if (i_flush) begin
            occ_nxt = OCC_EMPTY;
            cnt_nxt = '0;
        end else begin
            pkt_done_nxt = pop & head_last;
            if (push) begin
                cnt_nxt = new_last ? '0 : cnt + 1'b1;
            end
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        head_data_nxt = i_fifo_rddata;
                        head_last_nxt = new_last;
                        occ_nxt       = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            skid_data_nxt = i_fifo_rddata;
                            skid_last_nxt = new_last;
                            occ_nxt       = OCC_TWO;
                        end
                        2'b01: occ_nxt = OCC_EMPTY;
                        2'b11: begin
                            head_data_nxt = i_fifo_rddata;
                            head_last_nxt = new_last;
                        end
                        default: occ_nxt = OCC_ONE;
                    endcase
                end
                OCC_TWO: begin
                    if (pop) begin
                        head_data_nxt = skid_data;
                        head_last_nxt = skid_last;
                        occ_nxt       = OCC_ONE;
                    end
                end
                default: occ_nxt = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= OCC_EMPTY;
            head_data <= '0;
            head_last <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
            cnt       <= '0;
            pkt_done  <= 1'b0;
        end else begin
            occ       <= occ_nxt;
            head_data <= head_data_nxt;
            head_last <= head_last_nxt;
            skid_data <= skid_data_nxt;
            skid_last <= skid_last_nxt;
            cnt       <= cnt_nxt;
            pkt_done  <= pkt_done_nxt;
        end
    end

endmodule

// File: tb/tb_ram_fifo_stream_reader.sv
// Bench for ram_fifo_stream_reader: show-ahead FIFO model, queue-based stream
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_ram_fifo_stream_reader;

    localparam int DATA_W  = 8;
    localparam int PKT_LEN = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } word_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_en;
    logic              i_flush;
    logic              i_ready;
    logic              o_fifo_rden;
    logic [DATA_W-1:0] i_fifo_rddata;
    logic              i_fifo_empty;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_last;
    logic              o_pkt_done;

    logic [DATA_W-1:0] mem [0:63];
    int                wr_ptr = 0;
    int                rd_ptr = 0;
    logic              drop_req = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;

    word_t       exp_q[$];
    logic [8:0]  acc_log[$];
    int          acc_cyc[$];
    int          rd_cyc[$];
    int          pos = 0;
    logic        exp_done = 1'b0;
    logic        exp_zero = 1'b0;
    logic        live = 1'b0;

    ram_fifo_stream_reader #(
        .DATA_W (DATA_W),
        .PKT_LEN(PKT_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (i_en),
        .i_flush      (i_flush),
        .o_fifo_rden  (o_fifo_rden),
        .i_fifo_rddata(i_fifo_rddata),
        .i_fifo_empty (i_fifo_empty),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_last       (o_last),
        .o_pkt_done   (o_pkt_done)
    );

    always #5 clk = ~clk;

    assign i_fifo_empty  = (rd_ptr == wr_ptr);
    assign i_fifo_rddata = mem[rd_ptr % 64];

    always @(posedge clk) begin
        if (drop_req)
            rd_ptr <= wr_ptr;
        else if (o_fifo_rden)
            rd_ptr <= rd_ptr + 1;
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Outputs are sampled on the falling edge; the model then advances using
    // the inputs that the next rising edge will see.
    always @(negedge clk) begin
        logic  exp_valid;
        logic  exp_rden;
        logic  acc;
        word_t w;
        cyc++;
        exp_valid = (exp_q.size() != 0);
        exp_rden  = i_en && !i_fifo_empty && !i_flush && !rst && (exp_q.size() < 2);
        if (rst)
            check_eq("rden_in_reset", o_fifo_rden, 0);
        if (live) begin
            check_eq("o_valid", o_valid, exp_valid);
            if (exp_valid) begin
                check_eq("o_data", o_data, exp_q[0].data);
                check_eq("o_last", o_last, exp_q[0].last);
            end else if (exp_zero) begin
                check_eq("o_data_reset", o_data, 0);
                check_eq("o_last_reset", o_last, 0);
            end
            check_eq("o_pkt_done", o_pkt_done, exp_done);
            check_eq("o_fifo_rden", o_fifo_rden, exp_rden);
            check_eq("no_overflow", (o_fifo_rden === 1'b1) && (exp_q.size() == 2), 0);
            check_eq("no_underflow", (o_valid === 1'b1) && (i_ready === 1'b1) && (exp_q.size() == 0), 0);
        end
        if (o_fifo_rden === 1'b1)
            rd_cyc.push_back(cyc);
        if (o_valid === 1'b1 && i_ready === 1'b1 && !rst && !i_flush) begin
            acc_log.push_back({o_last, o_data});
            acc_cyc.push_back(cyc);
        end
        if (o_pkt_done === 1'b1)
            done_cnt++;
        if (rst || i_flush) begin
            exp_q.delete();
            pos      = 0;
            exp_done = 1'b0;
        end else begin
            acc      = exp_valid && i_ready;
            exp_done = acc && exp_q[0].last;
            if (acc)
                w = exp_q.pop_front();
            if (exp_rden) begin
                w.data = i_fifo_rddata;
                w.last = (pos == PKT_LEN - 1);
                exp_q.push_back(w);
                pos = (pos + 1) % PKT_LEN;
            end
        end
        exp_zero = rst;
        if (rst)
            live = 1'b1;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [DATA_W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 64] = first + DATA_W'(i);
            wr_ptr++;
        end
    endtask

    task automatic check_words(input string name, input int base, input logic [DATA_W-1:0] first,
                               input int n, input logic [7:0] lmask);
        check_eq({name, "_count"}, acc_log.size() - base, n);
        for (int i = 0; i < n && (base + i) < acc_log.size(); i++) begin
            check_eq({name, "_data"}, acc_log[base+i][7:0], first + DATA_W'(i));
            check_eq({name, "_last"}, acc_log[base+i][8], lmask[i]);
        end
    endtask

    initial begin
        int ab, rb, db, rb2;
        rst     = 1'b1;
        i_en    = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b0;
        load(8'hA0, 3);

        // Reset holds everything quiet even with a non-empty FIFO
        cycles(2);
        check_eq("reset_valid", o_valid, 0);
        check_eq("reset_data", o_data, 0);
        check_eq("reset_pkt_done", o_pkt_done, 0);
        rst      = 1'b0;
        i_en     = 1'b0;
        drop_req = 1'b1;
        cycles(1);
        drop_req = 1'b0;
        cycles(1);

        $display("[TB] streaming");
        ab = acc_log.size(); rb = rd_cyc.size(); db = done_cnt;
        load(8'h10, 8);
        i_ready = 1'b1;
        i_en    = 1'b1;
        cycles(12);
        check_eq("stream_reads", rd_cyc.size() - rb, 8);
        if (rd_cyc.size() - rb >= 8 && acc_cyc.size() > ab) begin
            check_eq("stream_rden_consecutive", rd_cyc[rb+7] - rd_cyc[rb], 7);
            check_eq("stream_latency", acc_cyc[ab] - rd_cyc[rb], 1);
        end
        check_words("stream", ab, 8'h10, 8, 8'b1000_1000);
        check_eq("stream_pkt_done", done_cnt - db, 2);
        i_en = 1'b0;
        cycles(2);

        $display("[TB] backpressure");
        i_ready = 1'b0;
        ab = acc_log.size(); rb = rd_cyc.size(); db = done_cnt;
        load(8'h10, 8);
        i_en = 1'b1;
        cycles(6);
        check_eq("bp_reads", rd_cyc.size() - rb, 2);
        check_eq("bp_hold_data", o_data, 8'h10);
        check_eq("bp_hold_valid", o_valid, 1);
        i_ready = 1'b1;
        cycles(12);
        check_words("bp", ab, 8'h10, 8, 8'b1000_1000);
        check_eq("bp_pkt_done", done_cnt - db, 2);

        $display("[TB] gap mid-packet");
        ab = acc_log.size();
        load(8'h20, 3);
        cycles(6);
        check_eq("gap_valid_drop", o_valid, 0);
        load(8'h23, 1);
        cycles(4);
        check_words("gap", ab, 8'h20, 4, 8'b0000_1000);

        $display("[TB] flush");
        i_ready = 1'b0;
        ab = acc_log.size(); rb = rd_cyc.size();
        load(8'h30, 6);
        cycles(4);
        check_eq("flush_pre_reads", rd_cyc.size() - rb, 2);
        i_flush = 1'b1;
        #1;
        check_eq("flush_no_read", o_fifo_rden, 0);
        cycles(1);
        i_flush = 1'b0;
        check_eq("flush_valid", o_valid, 0);
        i_ready = 1'b1;
        cycles(8);
        check_words("flush", ab, 8'h32, 4, 8'b0000_1000);

        $display("[TB] enable");
        i_ready = 1'b0;
        ab = acc_log.size(); rb = rd_cyc.size();
        load(8'h40, 6);
        cycles(4);
        check_eq("en_pre_reads", rd_cyc.size() - rb, 2);
        i_en    = 1'b0;
        i_ready = 1'b1;
        rb2     = rd_cyc.size();
        cycles(4);
        check_eq("en_no_reads", rd_cyc.size() - rb2, 0);
        check_eq("en_drained", acc_log.size() - ab, 2);
        check_eq("en_valid_after_drain", o_valid, 0);
        i_en = 1'b1;
        cycles(8);
        check_words("en", ab, 8'h40, 6, 8'b0000_1000);

        cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_fifo_stream_reader.md
Name: ram_fifo_stream_reader

Overview:
- Dequeue-side companion for the team's RAM FIFOs.
- Drains words through the FIFO's read-enable/empty/read-data interface.
- Presents them as a valid/ready stream through a 2-entry registered output buffer.
- Tags every PKT_LEN-th word as end-of-packet.
- Sits between a RAM FIFO and any downstream stream consumer (packetiser, serialiser, DMA).

Parameters:
- DATA_W, 8, data width in bits; must match the FIFO.
- PKT_LEN, 4, words per packet; must be >= 1. The word counter width is max(1, clog2(PKT_LEN)).

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- i_en  input  1  reader enable; gates FIFO reads only
- i_flush  input  1  synchronous flush of the output buffer and packet counter
- o_fifo_rden  output  1  FIFO read enable (combinational)
- i_fifo_rddata  input  DATA_W  FIFO read data; valid in the same cycle whenever i_fifo_empty=0 (show-ahead)
- i_fifo_empty  input  1  FIFO empty flag
- o_valid  output  1  stream data valid
- i_ready  input  1  stream consumer ready
- o_data  output  DATA_W  stream data
- o_last  output  1  end-of-packet tag for o_data
- o_pkt_done  output  1  one-cycle pulse, one cycle after a last word is accepted

Behaviour:
- Reset: one clock, synchronous, active-high (rst) is already decided.
  - While rst=1: occupancy=0, word counter=0, o_valid=0, o_data=0, o_last=0, o_pkt_done=0.
  - o_fifo_rden is forced to 0 while rst=1.
  - Reset asserted mid-packet discards buffered words and the packet position.
- Buffer:
  - Two entries, head and skid, each holding {data, last}. Occupancy is occ, range 0..2.
  - o_valid = (occ != 0). o_data and o_last come from the head entry and are registered.
- Read rule: o_fifo_rden = i_en & !i_fifo_empty & !i_flush & !rst & (occ < 2).
  - o_fifo_rden never depends on i_ready.
  - Data is sampled from i_fifo_rddata in the same cycle as o_fifo_rden.
- Latency: a word read at cycle N appears on o_data at cycle N+1 when the buffer is empty or the head is popped at N.
- Throughput: with i_ready held at 1, occ settles at 1 and the block sustains one word per cycle.
- Accept (pop) = o_valid & i_ready. Updates per cycle, keyed on occ and whether a push, pop, or both occur:
  - occ=0, push: head <= new; occ=1.
  - occ=1, push only: skid <= new; occ=2.
  - occ=1, pop only: occ=0.
  - occ=1, push and pop: head <= new; occ stays 1.
  - occ=2, pop: head <= skid; occ=1. A push cannot occur at occ=2.
- Stream rule: while o_valid=1 and i_ready=0, o_data and o_last hold stable. o_valid never drops without an accept, flush, or reset.
- Packet tagging:
  - The word counter advances on every FIFO read and wraps from PKT_LEN-1 to 0.
  - A word's last tag = (counter == PKT_LEN-1) at the time it is read.
  - With PKT_LEN=1, every word is tagged last.
  - FIFO emptiness mid-packet does not affect tagging; the counter only moves on reads.
- o_pkt_done: registered; 1 in the cycle after an accept with o_last=1, otherwise 0.
- i_flush: priority over push and pop. occ <= 0, counter <= 0, o_pkt_done <= 0, no FIFO read in that cycle. FIFO contents are untouched.
- i_en=0: no FIFO reads and the counter holds. Buffered words still drain via i_ready.
- Overflow/underflow: a push at occ=2 and a pop at occ=0 are impossible by construction. The verification bench asserts both.

Test Plan:
- Reset: FIFO holds 3 words, rst=1 for 2 cycles -> o_fifo_rden=0, o_valid=0, o_data=0, o_last=0, o_pkt_done=0 throughout.
- Streaming: PKT_LEN=4, FIFO holds 0x10..0x17, i_ready=1, i_en=1 -> o_fifo_rden high for 8 consecutive cycles. o_data 0x10..0x17 appears back-to-back starting 1 cycle after the first read. o_last=1 on 0x13 and 0x17. o_pkt_done pulses the cycle after each of those.
- Backpressure: same data, i_ready=0 for 6 cycles -> exactly 2 reads, then o_fifo_rden=0 and o_data holds 0x10. Then i_ready=1 -> 0x10, 0x11, 0x12, ... with no loss or duplication.
- Gap mid-packet: 3 words, FIFO empty for 5 cycles, then 1 word -> o_valid drops during the gap and o_last=1 only on the 4th word.
- Flush: occ=2 and counter=2, i_flush=1 for 1 cycle -> next cycle o_valid=0 and no read during the flush cycle. The next 4 words read are tagged last only on the 4th.
- Enable: occ=2, i_en=0, i_ready=1 -> both buffered words drain, no FIFO reads, and the counter is unchanged when i_en returns to 1.
